fetch_queue: RTL and testbench

//   Parametrised instruction-fetch unit, the successor to the bare pc + im pair.

---
 rtl/fetch_queue_if.sv | 45 ++++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module   : fetch_queue_if
// Purpose  : Bundles the instruction-memory read port, the redirect request
//            and the decode-side valid/ready stream of the fetch queue.
// Modports : master - the fetch unit (drives im_req/im_addr and out_*)
//            slave  - the environment (memory, branch unit, decode)
// Signals  : im_req, im_addr, im_data       instruction memory read port
//            redirect, redirect_pc          flush and restart fetch
//            out_valid, out_ready,
//            out_ins, out_pc                head of queue towards decode
//            count                          entries currently buffered
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              im_req;
   logic [ADDR_W-1:0] im_addr;
   logic [DATA_W-1:0] im_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_ins;
   logic [ADDR_W-1:0] out_pc;
   logic [CNT_W-1:0]  count;

   modport master (
      output im_req, im_addr, out_valid, out_ins, out_pc, count,
      input  im_data, redirect, redirect_pc, out_ready
   );

   modport slave (
      input  im_req, im_addr, out_valid, out_ins, out_pc, count,
      output im_data, redirect, redirect_pc, out_ready
   );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch unit. Owns the fetch PC, issues reads to a
//            synchronous instruction memory (1-cycle latency), buffers the
//            returned words with their PCs in a DEPTH-entry FIFO and presents
//            them to decode over valid/ready. A redirect flushes everything
//            and restarts fetch at redirect_pc.
// Ports    : clk  - clock, all state changes on rising edge
//            rst  - synchronous reset, active-low (0 = reset)
//            bus  - fetch_queue_if.master: im_req/im_addr/im_data,
//                   redirect/redirect_pc, out_valid/out_ready/out_ins/out_pc,
//                   count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic            clk,
   input  wire logic            rst,
   fetch_queue_if.master        bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W:0]    c_depth   = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q,    inflight_d;
   logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
   logic [CNT_W-1:0]  count_q,       count_d;

   logic [DATA_W-1:0] ins_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q  [DEPTH];

   logic              w_req;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W:0]    w_credit_used;

   // ------------------------------------------------------------------
   // Handshake decode and next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      // Credits count both buffered words and the read still in flight, so
      // a word returning next cycle always has a free slot even if decode
      // stalls. A same-cycle pop is deliberately not credited.
      w_credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      w_req         = rst & ~bus.redirect & (w_credit_used < c_depth);
      w_push        = inflight_q & ~bus.redirect;
      w_pop         = (count_q != '0) & bus.out_ready & ~bus.redirect;

      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = 1'b0;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (bus.redirect) begin
         // Flush: the head is killed and any in-flight response is dropped.
         fetch_pc_d = bus.redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end else begin
         if (w_req) begin
            fetch_pc_d    = fetch_pc_q + c_pc_step;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // FIFO storage (contents need no reset; count_q qualifies them)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst && w_push) begin
         ins_mem_q[wr_ptr_q] <= bus.im_data;
         pc_mem_q[wr_ptr_q]  <= inflight_pc_q;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.im_req    = w_req;
   assign bus.im_addr   = fetch_pc_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_ins   = ins_mem_q[rd_ptr_q];
   assign bus.out_pc    = pc_mem_q[rd_ptr_q];
   assign bus.count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue. Three instances
//            (DEPTH = 2, 4, 8) share clock, reset, redirect and out_ready.
//            The DEPTH=4 instance gets cycle-exact checks; every instance
//            has its popped stream compared against the expected PC sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

   localparam logic [31:0] c_pattern = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic        valid_w [3];
   logic        req_w   [3];
   logic [31:0] pc_w    [3];
   logic [31:0] ins_w   [3];
   logic [31:0] addr_w  [3];
   logic [3:0]  cnt_w   [3];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 2 : ((gi == 1) ? 4 : 8);

      fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(D)) u_if ();

      fetch_queue #(
         .ADDR_W   (32),
         .DATA_W   (32),
         .DEPTH    (D),
         .RESET_PC (32'h0000_0000)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if)
      );

      assign u_if.redirect    = redirect;
      assign u_if.redirect_pc = redirect_pc;
      assign u_if.out_ready   = out_ready;

      assign valid_w[gi] = u_if.out_valid;
      assign req_w[gi]   = u_if.im_req;
      assign pc_w[gi]    = u_if.out_pc;
      assign ins_w[gi]   = u_if.out_ins;
      assign addr_w[gi]  = u_if.im_addr;
      assign cnt_w[gi]   = 4'(u_if.count);

      // Synchronous instruction memory: word = address ^ pattern.
      always @(posedge clk) begin
         if (u_if.im_req) u_if.im_data <= u_if.im_addr ^ c_pattern;
      end

      // Every accepted word must continue the expected PC sequence.
      logic [31:0] exp_pc;
      always @(negedge clk) begin
         if (!rst) begin
            exp_pc = 32'h0;
         end else if (redirect) begin
            exp_pc = redirect_pc;
         end else if (u_if.out_valid && out_ready) begin
            check_eq($sformatf("stream_pc_d%0d", D), u_if.out_pc, exp_pc);
            check_eq($sformatf("stream_ins_d%0d", D), u_if.out_ins,
                     exp_pc ^ c_pattern);
            exp_pc = exp_pc + 32'd4;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      out_ready   = 1'b0;
      repeat (3) tick();

      // Reset state
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_valid", valid_w[i], 1'b0);
         check_eq("rst_count", cnt_w[i], 4'd0);
         check_eq("rst_req", req_w[i], 1'b0);
      end

      // Test 1: streaming from RESET_PC
      rst = 1'b1; out_ready = 1'b1; #1;
      check_eq("t1_req0", req_w[1], 1'b1);
      check_eq("t1_addr0", addr_w[1], 32'h0);
      tick();
      check_eq("t1_valid_early", valid_w[1], 1'b0);
      check_eq("t1_addr1", addr_w[1], 32'h4);
      tick();
      check_eq("t1_first_valid", valid_w[1], 1'b1);
      check_eq("t1_first_pc", pc_w[1], 32'h0);
      check_eq("t1_first_ins", ins_w[1], 32'hA5A5_0000);
      tick();
      check_eq("t1_pc4", pc_w[1], 32'h4);
      tick();
      check_eq("t1_pc8", pc_w[1], 32'h8);
      check_eq("t1_count_steady", cnt_w[1], 4'd1);

      // Test 2: stall until full, then drain
      out_ready = 1'b0;
      repeat (12) tick();
      check_eq("t2_full_d2", cnt_w[0], 4'd2);
      check_eq("t2_full_d4", cnt_w[1], 4'd4);
      check_eq("t2_full_d8", cnt_w[2], 4'd8);
      for (int i = 0; i < 3; i++) check_eq("t2_req_off", req_w[i], 1'b0);
      check_eq("t2_head_stable", pc_w[1], 32'h8);
      out_ready = 1'b1; #1;
      repeat (4) tick();
      check_eq("t2_resume_pc", pc_w[1], 32'h18);

      // Test 3: redirect with a partly filled queue and a read in flight
      out_ready = 1'b0;
      repeat (2) tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0100; #1;
      for (int i = 0; i < 3; i++) check_eq("t3_req_blocked", req_w[i], 1'b0);
      tick();
      redirect = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         check_eq("t3_flush_count", cnt_w[i], 4'd0);
         check_eq("t3_flush_valid", valid_w[i], 1'b0);
      end
      check_eq("t3_new_addr", addr_w[1], 32'h100);
      tick();
      check_eq("t3_valid_gap", valid_w[1], 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("t3_target_valid", valid_w[i], 1'b1);
         check_eq("t3_target_pc", pc_w[i], 32'h100);
         check_eq("t3_target_ins", ins_w[i], 32'hA5A5_0100);
      end

      // Test 4: redirect kills a presented head; back-to-back redirects
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
      tick();
      check_eq("t4_killed_count", cnt_w[1], 4'd0);
      redirect_pc = 32'h0000_0300; #1;
      check_eq("t4_req_blocked", req_w[1], 1'b0);
      tick();
      redirect = 1'b0; #1;
      check_eq("t4_last_wins_addr", addr_w[1], 32'h300);
      repeat (2) tick();
      check_eq("t4_valid", valid_w[1], 1'b1);
      check_eq("t4_pc300", pc_w[1], 32'h300);
      tick();
      check_eq("t4_pc304", pc_w[1], 32'h304);

      // Test 5: fetch PC wraps at the top of the address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      tick();
      redirect = 1'b0; #1;
      repeat (2) tick();
      check_eq("t5_pc_top", pc_w[1], 32'hFFFF_FFFC);
      tick();
      for (int i = 0; i < 3; i++) check_eq("t5_pc_wrap", pc_w[i], 32'h0);

      // Test 6: reset mid-stream with a read in flight
      repeat (3) tick();
      rst = 1'b0; #1;
      for (int i = 0; i < 3; i++) check_eq("t6_req_in_rst", req_w[i], 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("t6_valid", valid_w[i], 1'b0);
         check_eq("t6_count", cnt_w[i], 4'd0);
      end
      rst = 1'b1; #1;
      check_eq("t6_restart_addr", addr_w[1], 32'h0);
      repeat (2) tick();
      for (int i = 0; i < 3; i++) check_eq("t6_restart_pc", pc_w[i], 32'h0);
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
